// File: rtl/alu_multibyte_seq_if.sv
// Control-unit side of the multi-byte ALU sequencer: request fields, status
// and the active-low aggregate result flags.
interface alu_multibyte_seq_if;
  logic       start;
  logic [1:0] op_sel;
  logic [3:0] len;
  logic [7:0] a_base;
  logic [7:0] b_base;
  logic [7:0] d_base;
  logic       busy;
  logic       done;
  logic       _res_c;
  logic       _res_z;
  logic       _res_n;
  logic       _res_o;

  modport master (
    output start, op_sel, len, a_base, b_base, d_base,
    input  busy, done, _res_c, _res_z, _res_n, _res_o
  );

  modport slave (
    input  start, op_sel, len, a_base, b_base, d_base,
    output busy, done, _res_c, _res_z, _res_n, _res_o
  );
endinterface

// File: rtl/alu_multibyte_seq.sv
// Multi-byte add/subtract/compare sequencer: streams little-endian byte
// strings from RAM through the shared 8-bit ALU with a carry chain.
package alu_ops;
  localparam logic [4:0] OP_A_PLUS_B          = 5'h00;
  localparam logic [4:0] OP_A_PLUS_B_PLUS_C   = 5'h01;
  localparam logic [4:0] OP_A_MINUS_B         = 5'h02;
  localparam logic [4:0] OP_A_MINUS_B_MINUS_C = 5'h03;
endpackage

module alu_multibyte_seq #(
  parameter int ALU_WAIT = 2,
  parameter int LOG      = 0
) (
  input  logic                 clk,
  input  logic                 _reset,
  alu_multibyte_seq_if.slave   ctl,
  output logic [7:0]           mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [4:0]           alu_op,
  input  logic [7:0]           alu_o,
  input  logic                 _alu_flag_c,
  input  logic                 _alu_flag_n,
  input  logic                 _alu_flag_o
);
  import alu_ops::*;

  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_LATB, S_ALU, S_WB, S_DONE
  } state_t;

  state_t          state_r, next_state_s;
  logic [1:0]      op_r;
  logic [3:0]      len_r, idx_r;
  logic [7:0]      a_base_r, b_base_r, d_base_r, a_reg_r;
  logic            cy_r, nz_r;
  logic [CW-1:0]   wait_r;
  logic            busy_r, done_r, mem_we_r;
  logic [7:0]      mem_addr_r, mem_wdata_r, alu_a_r, alu_b_r;
  logic [4:0]      alu_op_r;
  logic            res_c_r, res_z_r, res_n_r, res_o_r;
  logic [7:0]      nxt_addr_s, nxt_wdata_s, nxt_alu_a_s, nxt_alu_b_s;
  logic [4:0]      nxt_alu_op_s;
  logic            nxt_we_s, nxt_res_c_s, nxt_res_z_s, nxt_res_n_s, nxt_res_o_s;
  logic            is_sub_s, is_cmp_s, last_s;
  logic            unused_log_s;

  // LOG only selects a simulation trace; it has no effect on the hardware.
  assign unused_log_s = (LOG != 0);

  assign is_sub_s = (op_r != 2'd0);
  assign is_cmp_s = op_r[1];
  assign last_s   = ((idx_r + 4'd1) == len_r);

  // Next state and next values of every registered output.
  always_comb begin
    next_state_s = state_r;
    nxt_addr_s   = mem_addr_r;
    nxt_we_s     = 1'b0;
    nxt_wdata_s  = mem_wdata_r;
    nxt_alu_a_s  = alu_a_r;
    nxt_alu_b_s  = alu_b_r;
    nxt_alu_op_s = alu_op_r;
    nxt_res_c_s  = res_c_r;
    nxt_res_z_s  = res_z_r;
    nxt_res_n_s  = res_n_r;
    nxt_res_o_s  = res_o_r;
    case (state_r)
      S_IDLE: begin
        if (ctl.start) begin
          nxt_res_c_s = 1'b1;
          nxt_res_z_s = 1'b1;
          nxt_res_n_s = 1'b1;
          nxt_res_o_s = 1'b1;
          if (ctl.len == 4'd0) begin
            next_state_s = S_DONE;
            nxt_res_z_s  = 1'b0;
          end else begin
            next_state_s = S_RDA;
            nxt_addr_s   = ctl.a_base;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RDA: begin
        next_state_s = S_RDB;
        nxt_addr_s   = b_base_r + {4'd0, idx_r};
      end
      S_RDB:  next_state_s = S_LATB;
      S_LATB: begin
        next_state_s = S_ALU;
        nxt_alu_a_s  = a_reg_r;
        nxt_alu_b_s  = mem_rdata;
        if (is_sub_s) begin
          nxt_alu_op_s = cy_r ? OP_A_MINUS_B_MINUS_C : OP_A_MINUS_B;
        end else begin
          nxt_alu_op_s = cy_r ? OP_A_PLUS_B_PLUS_C : OP_A_PLUS_B;
        end
      end
      S_ALU: begin
        if (wait_r == CW'(1'b1)) begin
          next_state_s = S_WB;
          nxt_addr_s   = d_base_r + {4'd0, idx_r};
          nxt_we_s     = !is_cmp_s;
          nxt_wdata_s  = alu_o;
        end else begin
          next_state_s = S_ALU;
        end
      end
      S_WB: begin
        if (last_s) begin
          // Flags are active low; nz set means some byte was nonzero.
          next_state_s = S_DONE;
          nxt_res_c_s  = _alu_flag_c;
          nxt_res_z_s  = nz_r | (alu_o != 8'd0);
          nxt_res_n_s  = _alu_flag_n;
          nxt_res_o_s  = _alu_flag_o;
        end else begin
          next_state_s = S_RDA;
          nxt_addr_s   = a_base_r + {4'd0, idx_r + 4'd1};
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_addr_r  <= 8'd0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= 8'd0;
      alu_a_r     <= 8'd0;
      alu_b_r     <= 8'd0;
      alu_op_r    <= OP_A_PLUS_B;
      res_c_r     <= 1'b1;
      res_z_r     <= 1'b1;
      res_n_r     <= 1'b1;
      res_o_r     <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != S_IDLE);
      done_r      <= (next_state_s == S_DONE);
      mem_addr_r  <= nxt_addr_s;
      mem_we_r    <= nxt_we_s;
      mem_wdata_r <= nxt_wdata_s;
      alu_a_r     <= nxt_alu_a_s;
      alu_b_r     <= nxt_alu_b_s;
      alu_op_r    <= nxt_alu_op_s;
      res_c_r     <= nxt_res_c_s;
      res_z_r     <= nxt_res_z_s;
      res_n_r     <= nxt_res_n_s;
      res_o_r     <= nxt_res_o_s;
    end
  end

  // Request latch, byte index, carry/borrow chain and ALU settle counter.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      op_r     <= 2'd0;
      len_r    <= 4'd0;
      a_base_r <= 8'd0;
      b_base_r <= 8'd0;
      d_base_r <= 8'd0;
      idx_r    <= 4'd0;
      cy_r     <= 1'b0;
      nz_r     <= 1'b0;
      a_reg_r  <= 8'd0;
      wait_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ctl.start) begin
            op_r     <= ctl.op_sel;
            len_r    <= ctl.len;
            a_base_r <= ctl.a_base;
            b_base_r <= ctl.b_base;
            d_base_r <= ctl.d_base;
            idx_r    <= 4'd0;
            cy_r     <= 1'b0;
            nz_r     <= 1'b0;
          end
        end
        S_RDB:  a_reg_r <= mem_rdata;
        S_LATB: wait_r  <= CW'(ALU_WAIT);
        S_ALU:  wait_r  <= wait_r - CW'(1'b1);
        S_WB: begin
          cy_r  <= !_alu_flag_c;
          nz_r  <= nz_r | (alu_o != 8'd0);
          idx_r <= idx_r + 4'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign ctl.busy   = busy_r;
  assign ctl.done   = done_r;
  assign ctl._res_c = res_c_r;
  assign ctl._res_z = res_z_r;
  assign ctl._res_n = res_n_r;
  assign ctl._res_o = res_o_r;
  assign mem_addr   = mem_addr_r;
  assign mem_we     = mem_we_r;
  assign mem_wdata  = mem_wdata_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_op     = alu_op_r;
endmodule
